// File: rtl/chan_scan_mux.sv
// chan_scan_mux: channel scanner/multiplexer with prescaled auto-scan, manual select and enable blanking
module chan_scan_mux #(
    parameter int CH    = 4,
    parameter int W     = 4,
    parameter int DIV   = 100000,
    parameter int BLANK = 0,
    localparam int SW   = CH > 2 ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH*W-1:0] data,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    input  logic            hold,
    output logic [W-1:0]    y,
    output logic [SW-1:0]   ch,
    output logic [CH-1:0]   en_n,
    output logic            tick
);
    localparam int CW = $clog2(DIV);
    localparam int BW = BLANK > 1 ? $clog2(BLANK) : 1;

    logic [CW-1:0] cnt, cnt_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [SW-1:0] ch_n;
    logic [CH-1:0] en_n_n;
    logic [W-1:0]  y_n;
    logic          mode_q, init, rise, wrap, tick_n, chg;

    // next-state: prescaler, channel selection, blanking and output data
    always_comb begin
        rise   = mode & ~mode_q;
        wrap   = cnt == CW'(DIV - 1);
        cnt_n  = (rise | wrap) ? '0 : cnt + 1'b1;
        tick_n = wrap & ~rise;
        ch_n   = !mode ? ((32'(sel) < CH) ? sel : ch)
               : (tick_n & ~hold) ? ((ch == SW'(CH - 1)) ? '0 : ch + 1'b1) : ch;
        chg    = init && (BLANK > 0) && (ch_n != ch);
        bcnt_n = chg ? BW'(BLANK > 0 ? BLANK - 1 : 0) : (bcnt != '0 ? bcnt - 1'b1 : bcnt);
        en_n_n = (chg || bcnt != '0) ? '1 : ~(CH'(1) << ch_n);
        y_n    = data[ch_n*W +: W];
    end

    // state register; init suppresses blanking on the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            ch     <= '0;
            y      <= '0;
            en_n   <= '1;
            tick   <= 1'b0;
            bcnt   <= '0;
            mode_q <= 1'b0;
            init   <= 1'b0;
        end else begin
            cnt    <= cnt_n;
            ch     <= ch_n;
            y      <= y_n;
            en_n   <= en_n_n;
            tick   <= tick_n;
            bcnt   <= bcnt_n;
            mode_q <= mode;
            init   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: directed checks of chan_scan_mux (CH=4 and CH=3, DIV=4, BLANK=1)
module tb_chan_scan_mux;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic [15:0] data;
    logic [1:0]  sel, ch;
    logic        mode, hold, tick;
    logic [3:0]  y, en_n;
    logic [11:0] data3;
    logic [1:0]  sel3, ch3;
    logic        mode3, tick3;
    logic [3:0]  y3;
    logic [2:0]  en3;
    int total = 0, bad = 0, ticks, blanks;

    chan_scan_mux #(.CH(4), .W(4), .DIV(4), .BLANK(1)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .sel(sel), .mode(mode), .hold(hold),
        .y(y), .ch(ch), .en_n(en_n), .tick(tick));

    chan_scan_mux #(.CH(3), .W(4), .DIV(4), .BLANK(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .data(data3), .sel(sel3), .mode(mode3), .hold(1'b0),
        .y(y3), .ch(ch3), .en_n(en3), .tick(tick3));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        mode = 1; hold = 0; sel = 0; data = 16'hDCBA;
        mode3 = 0; sel3 = 2; data3 = 12'h987;
        #2 rst_n = 0;
        #1;
        chk("rst_y", y, 0); chk("rst_ch", ch, 0); chk("rst_en", en_n, 4'hF); chk("rst_tick", tick, 0);
        @(negedge clk) rst_n = 1;
        step();
        chk("e1_ch", ch, 0); chk("e1_y", y, 4'hA); chk("e1_en", en_n, 4'b1110); chk("e1_tick", tick, 0);
        chk("n3_ch", ch3, 2); chk("n3_y", y3, 4'h9); chk("n3_en_noblank", en3, 3'b011);
        sel3 = 3;
        step();
        chk("n3_selbad_hold", ch3, 2);
        chk("e2_tick", tick, 0);
        mode3 = 1;
        step(); step(); step();
        chk("e5_tick", tick, 1); chk("e5_ch", ch, 1); chk("e5_y", y, 4'hB); chk("e5_blank", en_n, 4'hF);
        step();
        chk("e6_tick", tick, 0); chk("e6_en", en_n, 4'b1101);
        step();
        chk("n3_wrap_ch", ch3, 0); chk("n3_wrap_y", y3, 4'h7); chk("n3_blank", en3, 3'b111);
        step(); step();
        chk("e9_ch", ch, 2); chk("e9_y", y, 4'hC);
        hold = 1; ticks = 0; blanks = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("hold_ch", ch, 2);
            if (tick) ticks++;
            if (en_n == 4'hF) blanks++;
        end
        chk("hold_ticks", ticks, 3); chk("hold_blanks", blanks, 0); chk("hold_y", y, 4'hC);
        hold = 0;
        step(); step(); step(); step();
        chk("e25_ch", ch, 3); chk("e25_y", y, 4'hD); chk("e25_tick", tick, 1);
        step();
        chk("e26_en", en_n, 4'b0111);
        step(); step(); step();
        chk("wrap_ch", ch, 0); chk("wrap_y", y, 4'hA); chk("wrap_blank", en_n, 4'hF);
        step();
        chk("wrap_en", en_n, 4'b1110);
        mode = 0; sel = 3;
        step();
        chk("man3_ch", ch, 3); chk("man3_y", y, 4'hD); chk("man3_blank", en_n, 4'hF);
        step();
        chk("man3_en", en_n, 4'b0111);
        sel = 1;
        step();
        chk("man1_ch", ch, 1); chk("man1_y", y, 4'hB); chk("man1_blank", en_n, 4'hF);
        step();
        chk("man1_en", en_n, 4'b1101);
        sel = 0;
        step(); step();
        chk("man0_en", en_n, 4'b1110);
        data = 16'hDCB5;
        chk("data_pre", y, 4'hA);
        step();
        chk("data_y", y, 4'h5); chk("data_en", en_n, 4'b1110);
        mode = 1;
        step();
        chk("rise_tick", tick, 0); chk("rise_ch", ch, 0);
        step(); step(); step(); step();
        chk("cont_ch", ch, 1); chk("cont_y", y, 4'hB);
        for (int i = 0; i < 8; i++) step();
        chk("pre_rst_ch", ch, 3);
        step();
        chk("pre_rst_en", en_n, 4'b0111);
        #2 rst_n = 0;
        #1;
        chk("arst_y", y, 0); chk("arst_ch", ch, 0); chk("arst_en", en_n, 4'hF); chk("arst_tick", tick, 0);
        @(negedge clk) rst_n = 1;
        step();
        chk("rel_ch", ch, 0); chk("rel_y", y, 4'h5); chk("rel_en", en_n, 4'b1110); chk("rel_tick", tick, 0);
        step(); step(); step();
        chk("rel_tick3", tick, 0);
        step();
        chk("rel_tick4", tick, 1); chk("rel_ch4", ch, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
